// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, default baud divisor and the TX drain state encoding.
package uart_pkg;

  localparam int UART_DATA_BITS       = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz / 115200

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running baud counter 0..CLKS_PER_BIT-1 with synchronous clear.
// tick marks the last cycle of a bit; pre_tick marks the cycle before it.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 434,
  localparam int CNT_W = $clog2(CLKS_PER_BIT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick,
  output logic pre_tick
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick     = (cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign pre_tick = (cnt == CNT_W'(CLKS_PER_BIT - 2));

endmodule

// File: rtl/uart_tx_drain.sv
// Drains bytes from the ring buffer read port and serialises each one as UART 8N1 on tx.
// Buffer handshake: buf_ren pulses for one cycle (REQ); buf_available is only honoured in the following cycle (WAIT).
module uart_tx_drain
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] buf_data,
  input  logic       buf_available,
  output logic       buf_ren,
  output logic       tx,
  output logic       busy,
  output logic       sent,
  output tx_state_t  state_dbg
);

  tx_state_t  state, next_state;
  logic [7:0] shreg;
  logic [2:0] idx;
  logic       tick, pre_tick, clr;
  logic       tx_d, buf_ren_d, busy_d, sent_d;

  // The counter is held at zero across WAIT so START begins a full bit period.
  assign clr = (state == WAIT);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (en) next_state = REQ;
      REQ:     next_state = WAIT;
      WAIT:    next_state = buf_available ? START : IDLE;
      START:   if (tick) next_state = DATA;
      DATA:    if (tick && idx == 3'(UART_DATA_BITS - 1)) next_state = STOP;
      STOP:    if (tick) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (state == WAIT && buf_available) begin
      shreg <= buf_data;
      idx   <= '0;
    end else if (state == DATA && tick) begin
      shreg <= shreg >> 1;
      idx   <= idx + 3'd1;
    end
  end

  // Outputs are computed for the upcoming state so the registered pins line up with it.
  always_comb begin
    buf_ren_d = (next_state == REQ);
    busy_d    = (next_state != IDLE);
    sent_d    = (state == STOP) && pre_tick;
    case (next_state)
      START:   tx_d = 1'b0;
      DATA:    tx_d = (state == DATA && tick) ? shreg[1] : shreg[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx      <= 1'b1;
      buf_ren <= 1'b0;
      busy    <= 1'b0;
      sent    <= 1'b0;
    end else begin
      tx      <= tx_d;
      buf_ren <= buf_ren_d;
      busy    <= busy_d;
      sent    <= sent_d;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with CLKS_PER_BIT=4 and a behavioural ring-buffer model.
module tb_uart_tx_drain;
  import uart_pkg::*;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] buf_data;
  logic       buf_available;
  logic       buf_ren;
  logic       tx;
  logic       busy;
  logic       sent;
  tx_state_t  state_dbg;

  logic [7:0] mem_q[$];
  logic [7:0] exp_q[$];
  int         errors = 0;
  int         checks = 0;
  int         pops   = 0;

  uart_tx_drain #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .buf_data      (buf_data),
    .buf_available (buf_available),
    .buf_ren       (buf_ren),
    .tx            (tx),
    .busy          (busy),
    .sent          (sent),
    .state_dbg     (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Ring buffer model: a ren seen in one cycle yields data in the next cycle, if any is queued.
  initial begin
    logic ren_seen;
    buf_available = 1'b0;
    buf_data      = 8'h00;
    forever begin
      @(negedge clk);
      ren_seen = buf_ren;
      @(posedge clk);
      #1;
      buf_available = 1'b0;
      if (ren_seen && mem_q.size() > 0) begin
        buf_data      = mem_q.pop_front();
        buf_available = 1'b1;
        pops++;
      end
    end
  end

  function automatic logic [FRAME-1:0] frame_of(input logic [7:0] b);
    logic [FRAME-1:0] f;
    int k;
    for (int i = 0; i < FRAME; i++) begin
      k = i / CPB;
      if (k == 0)      f[i] = 1'b0;
      else if (k == 9) f[i] = 1'b1;
      else             f[i] = b[k-1];
    end
    return f;
  endfunction

  // Driver/capture: waits for a start bit, then records one frame sampled at negedges.
  task automatic capture_frame(input int drop_at, input int max_wait,
                               output logic [FRAME-1:0] bits, output int pre_idle,
                               output int sent_cnt, output bit sent_last, output bit timed_out);
    timed_out = 1'b0;
    pre_idle  = 0;
    sent_cnt  = 0;
    sent_last = 1'b0;
    bits      = '1;
    @(negedge clk);
    while (tx !== 1'b0 && pre_idle < max_wait) begin
      pre_idle++;
      @(negedge clk);
    end
    if (tx !== 1'b0) begin
      timed_out = 1'b1;
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0) @(negedge clk);
      bits[i] = tx;
      if (sent === 1'b1) begin
        sent_cnt++;
        if (i == FRAME - 1) sent_last = 1'b1;
      end
      if (i == drop_at) en = 1'b0;
    end
  endtask

  task automatic settle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    int ren_hits, tx_low, busy_hi;
    rst = 1'b1;
    en  = 1'b0;
    settle(5);
    checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (buf_ren !== 1'b0) begin errors++; $display("FAIL reset_ren: got %b expected 0", buf_ren); end
    checks++; if (sent !== 1'b0)    begin errors++; $display("FAIL reset_sent: got %b expected 0", sent); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state_dbg, IDLE); end
    rst = 1'b0;
    ren_hits = 0; tx_low = 0; busy_hi = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (buf_ren !== 1'b0) ren_hits++;
      if (tx !== 1'b1)      tx_low++;
      if (busy !== 1'b0)    busy_hi++;
    end
    checks++; if (ren_hits != 0) begin errors++; $display("FAIL idle_ren: got %0d pulses expected 0", ren_hits); end
    checks++; if (tx_low != 0)   begin errors++; $display("FAIL idle_tx: got %0d low cycles expected 0", tx_low); end
    checks++; if (busy_hi != 0)  begin errors++; $display("FAIL idle_busy: got %0d busy cycles expected 0", busy_hi); end
  endtask

  task automatic test_poll_empty;
    int pulses, consec, bad_gap, tx_low, last;
    logic prev;
    pulses = 0; consec = 0; bad_gap = 0; tx_low = 0; last = -1; prev = 1'b0;
    en = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (buf_ren === 1'b1) begin
        pulses++;
        if (prev) consec++;
        if (last >= 0 && i - last != 3) bad_gap++;
        last = i;
      end
      prev = (buf_ren === 1'b1);
      if (tx !== 1'b1) tx_low++;
    end
    en = 1'b0;
    settle(4);
    checks++; if (pulses != 10) begin errors++; $display("FAIL poll_pulses: got %0d expected 10", pulses); end
    checks++; if (consec != 0)  begin errors++; $display("FAIL poll_consecutive: got %0d expected 0", consec); end
    checks++; if (bad_gap != 0) begin errors++; $display("FAIL poll_cadence: got %0d bad gaps expected 0", bad_gap); end
    checks++; if (tx_low != 0)  begin errors++; $display("FAIL poll_tx: got %0d low cycles expected 0", tx_low); end
  endtask

  task automatic test_single;
    logic [FRAME-1:0] bits;
    int pre, scnt;
    bit slast, tmo;
    mem_q.push_back(8'h55);
    en = 1'b1;
    capture_frame(-1, 20, bits, pre, scnt, slast, tmo);
    en = 1'b0;
    checks++; if (tmo)                    begin errors++; $display("FAIL single_start: got timeout expected start bit"); end
    checks++; if (pre != 2)               begin errors++; $display("FAIL single_latency: got %0d expected 2", pre); end
    checks++; if (bits !== frame_of(8'h55)) begin errors++; $display("FAIL single_frame: got %h expected %h", bits, frame_of(8'h55)); end
    checks++; if (scnt != 1)              begin errors++; $display("FAIL single_sent_count: got %0d expected 1", scnt); end
    checks++; if (!slast)                 begin errors++; $display("FAIL single_sent_pos: got 0 expected 1 on last stop cycle"); end
    @(negedge clk);
    checks++; if (sent !== 1'b0 || tx !== 1'b1) begin errors++; $display("FAIL single_after: got sent=%b tx=%b expected 0 1", sent, tx); end
    settle(4);
  endtask

  task automatic test_back_to_back;
    logic [FRAME-1:0] bits1, bits2;
    logic [7:0] e;
    int pre1, pre2, s1, s2, pops0;
    bit l1, l2, t1, t2;
    pops0 = pops;
    mem_q.push_back(8'hA3); exp_q.push_back(8'hA3);
    mem_q.push_back(8'h0F); exp_q.push_back(8'h0F);
    en = 1'b1;
    capture_frame(-1, 20, bits1, pre1, s1, l1, t1);
    capture_frame(-1, 20, bits2, pre2, s2, l2, t2);
    en = 1'b0;
    checks++; if (t1 || t2) begin errors++; $display("FAIL b2b_start: got timeout expected two frames"); end
    e = exp_q.pop_front();
    checks++; if (bits1 !== frame_of(e)) begin errors++; $display("FAIL b2b_frame1: got %h expected %h", bits1, frame_of(e)); end
    e = exp_q.pop_front();
    checks++; if (bits2 !== frame_of(e)) begin errors++; $display("FAIL b2b_frame2: got %h expected %h", bits2, frame_of(e)); end
    checks++; if (pre2 != 3) begin errors++; $display("FAIL b2b_gap: got %0d idle cycles expected 3", pre2); end
    checks++; if (s1 != 1 || s2 != 1 || !l1 || !l2) begin errors++; $display("FAIL b2b_sent: got %0d/%0d expected 1/1 on last cycle", s1, s2); end
    settle(6);
    checks++; if (pops - pops0 != 2) begin errors++; $display("FAIL b2b_pops: got %0d expected 2", pops - pops0); end
  endtask

  task automatic test_en_drop;
    logic [FRAME-1:0] bits;
    int pre, scnt, ren_hits, tx_low, wait_n;
    bit slast, tmo;
    mem_q.push_back(8'hFF);
    en = 1'b1;
    capture_frame(4 * CPB, 20, bits, pre, scnt, slast, tmo);
    checks++; if (tmo || bits !== frame_of(8'hFF)) begin errors++; $display("FAIL drop_frame: got %h expected %h", bits, frame_of(8'hFF)); end
    checks++; if (scnt != 1) begin errors++; $display("FAIL drop_sent: got %0d expected 1", scnt); end
    ren_hits = 0; tx_low = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (buf_ren === 1'b1) ren_hits++;
      if (tx !== 1'b1)      tx_low++;
    end
    checks++; if (ren_hits != 0) begin errors++; $display("FAIL drop_no_req: got %0d pulses expected 0", ren_hits); end
    checks++; if (tx_low != 0)   begin errors++; $display("FAIL drop_tx_idle: got %0d low cycles expected 0", tx_low); end
    en = 1'b1;
    wait_n = 0;
    @(negedge clk);
    while (buf_ren !== 1'b1 && wait_n < 6) begin
      wait_n++;
      @(negedge clk);
    end
    checks++; if (buf_ren !== 1'b1) begin errors++; $display("FAIL drop_resume: got no ren expected a pulse within 6 cycles"); end
    en = 1'b0;
    settle(4);
  endtask

  task automatic test_reset_mid;
    int wait_n, tx_low, pops0;
    pops0 = pops;
    mem_q.push_back(8'h00);
    en = 1'b1;
    wait_n = 0;
    @(negedge clk);
    while (tx !== 1'b0 && wait_n < 20) begin
      wait_n++;
      @(negedge clk);
    end
    settle(CPB * 2 + 2);
    checks++; if (tx !== 1'b0 || state_dbg !== DATA) begin errors++; $display("FAIL mid_in_data: got tx=%b state=%0d expected 0 %0d", tx, state_dbg, DATA); end
    rst = 1'b1;
    #1;
    checks++; if (tx !== 1'b1)   begin errors++; $display("FAIL mid_async_tx: got %b expected 1", tx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy: got %b expected 0", busy); end
    checks++; if (state_dbg !== IDLE) begin errors++; $display("FAIL mid_async_state: got %0d expected %0d", state_dbg, IDLE); end
    settle(2);
    rst = 1'b0;
    tx_low = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) tx_low++;
    end
    en = 1'b0;
    checks++; if (tx_low != 0)       begin errors++; $display("FAIL mid_no_retx: got %0d low cycles expected 0", tx_low); end
    checks++; if (pops - pops0 != 1) begin errors++; $display("FAIL mid_pops: got %0d expected 1", pops - pops0); end
    settle(4);
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_poll_empty();
    test_single();
    test_back_to_back();
    test_en_drop();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
